// File: rtl/aes_dec_arbiter.sv
// Two-requester round-robin front end for a single AES decipher core.
// One operation is in flight at a time; the result returns to the requester that issued it.
module aes_dec_arbiter #(
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            in_valid,
    input  logic [DATA_WIDTH-1:0] in_data0,
    input  logic [DATA_WIDTH-1:0] in_data1,
    output logic [1:0]            in_ready,
    output logic [1:0]            out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic [1:0]            out_ready,
    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_cyphertext,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_plaintext,
    output logic                  busy,
    output logic                  err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  owner_q, owner_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] cyph_q, cyph_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  grant_vld;
    logic                  grant_idx;
    logic                  accept;
    logic                  timeout_hit;

    // Round-robin grant: the favoured requester wins, otherwise the other one.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_q;
        if (in_valid[rr_q]) begin
            grant_vld = 1'b1;
            grant_idx = rr_q;
        end else if (in_valid[~rr_q]) begin
            grant_vld = 1'b1;
            grant_idx = ~rr_q;
        end
    end

    assign accept = (state_q == ST_IDLE) && grant_vld && !rst;

    // A done arriving on the last allowed cycle wins over the timeout.
    assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == TIMEOUT_LIMIT) && !core_done;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        cyph_d     = cyph_q;
        out_data_d = out_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = grant_idx;
                    cyph_d  = grant_idx ? in_data1 : in_data0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    out_data_d = core_plaintext;
                    state_d    = ST_RESP;
                end else if (cnt_q == TIMEOUT_LIMIT) begin
                    rr_d    = ~owner_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (out_ready[owner_q]) begin
                    rr_d    = ~owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset too because out_data and core_cyphertext are visible ports.
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= 8'd0;
            cyph_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            cyph_q     <= cyph_d;
            out_data_q <= out_data_d;
        end
    end

    // Handshake outputs are masked during reset so an abandoned operation emits nothing.
    assign in_ready        = {accept & grant_idx, accept & ~grant_idx};
    assign out_valid       = ((state_q == ST_RESP) && !rst) ? {owner_q, ~owner_q} : 2'b00;
    assign err_timeout     = timeout_hit && !rst;
    assign core_start      = (state_q == ST_START);
    assign busy            = (state_q != ST_IDLE);
    assign core_cyphertext = cyph_q;
    assign out_data        = out_data_q;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Directed bench for aes_dec_arbiter with a two-cycle behavioural decipher core
// that answers from a table of AES-128 known-answer vectors.
module tb_aes_dec_arbiter;

    localparam int DW = 128;

    localparam logic [DW-1:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [DW-1:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] CT_A    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [DW-1:0] PT_A    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [DW-1:0] CT_B    = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [DW-1:0] PT_B    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [DW-1:0] SPUR    = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    in_valid;
    logic [DW-1:0] in_data0, in_data1;
    logic [1:0]    in_ready, out_valid, out_ready;
    logic [DW-1:0] out_data, core_cyphertext, core_plaintext;
    logic          core_start, core_done, busy, err_timeout;

    int checks = 0;
    int errors = 0;

    logic core_en    = 1'b1;
    logic force_done = 1'b0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;

    aes_dec_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .core_start(core_start), .core_cyphertext(core_cyphertext),
        .core_done(core_done), .core_plaintext(core_plaintext),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_pt(input logic [DW-1:0] ct);
        case (ct)
            FIPS_CT: ref_pt = FIPS_PT;
            CT_A:    ref_pt = PT_A;
            CT_B:    ref_pt = PT_B;
            default: ref_pt = '0;
        endcase
    endfunction

    // Reference core: done two cycles after the start pulse is sampled.
    always @(posedge clk) begin
        s1 <= core_start;
        s2 <= s1;
    end
    assign core_done      = (s2 & core_en) | force_done;
    assign core_plaintext = force_done ? SPUR : ref_pt(core_cyphertext);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        in_valid = 2'b00; out_ready = 2'b00; force_done = 1'b0; core_en = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 2'b11; in_data0 = FIPS_CT; in_data1 = CT_B; out_ready = 2'b00;
        tick();
        tick();
        checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL reset_in_ready: got %b want 00", in_ready); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", core_start); end
        checks++; if (core_cyphertext !== '0) begin errors++; $display("FAIL reset_core_ct: got %h want 0", core_cyphertext); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        in_valid = 2'b00;
        rst = 1'b0;
        settle();
    endtask

    task automatic test_single();
        in_data0 = FIPS_CT; in_valid = 2'b01;
        settle();
        checks++; if (in_ready !== 2'b01) begin errors++; $display("FAIL single_in_ready: got %b want 01", in_ready); end
        tick();                                   // k+1
        in_valid = 2'b00;
        settle();
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL single_start_k1: got %b want 1", core_start); end
        checks++; if (core_cyphertext !== FIPS_CT) begin errors++; $display("FAIL single_core_ct: got %h want %h", core_cyphertext, FIPS_CT); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();                                   // k+2
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL single_start_k2: got %b want 0", core_start); end
        tick();                                   // k+3
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL single_early_valid: got %b want 00", out_valid); end
        tick();                                   // k+4
        checks++; if (out_valid !== 2'b01) begin errors++; $display("FAIL single_out_valid_k4: got %b want 01", out_valid); end
        checks++; if (out_data !== FIPS_PT) begin errors++; $display("FAIL single_out_data: got %h want %h", out_data, FIPS_PT); end
        out_ready = 2'b01;
        tick();
        out_ready = 2'b00;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: got busy %b want 0", busy); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL single_valid_drop: got %b want 00", out_valid); end
    endtask

    task automatic test_contention();
        logic [1:0]    exp_sel;
        logic [DW-1:0] exp_pt;
        logic          got;
        do_reset();
        in_data0 = CT_A; in_data1 = CT_B; in_valid = 2'b11; out_ready = 2'b11;
        settle();
        for (int t = 0; t < 4; t++) begin
            exp_sel = t[0] ? 2'b10 : 2'b01;
            exp_pt  = t[0] ? PT_B : PT_A;
            checks++; if (in_ready !== exp_sel) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", t, in_ready, exp_sel); end
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                checks++; if (!$onehot0(out_valid)) begin errors++; $display("FAIL contention_onehot: got %b want at most one bit", out_valid); end
                if (out_valid !== 2'b00) got = 1'b1;
            end
            if (!got) begin
                checks++; errors++; $display("FAIL contention_wait%0d: got no out_valid want %b within 10 cycles", t, exp_sel);
            end else begin
                checks++; if (out_valid !== exp_sel) begin errors++; $display("FAIL contention_owner%0d: got %b want %b", t, out_valid, exp_sel); end
                checks++; if (out_data !== exp_pt) begin errors++; $display("FAIL contention_data%0d: got %h want %h", t, out_data, exp_pt); end
            end
            tick();
        end
        in_valid = 2'b00; out_ready = 2'b00;
        settle();
    endtask

    task automatic test_backpressure();
        logic got;
        in_data1 = CT_B; in_valid = 2'b10;
        settle();
        checks++; if (in_ready !== 2'b10) begin errors++; $display("FAIL bp_grant: got %b want 10", in_ready); end
        tick();
        // The losing requester keeps asking and the non-owner out_ready bit is set.
        in_valid = 2'b11; in_data0 = CT_A; out_ready = 2'b01;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (out_valid !== 2'b00) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++; $display("FAIL bp_wait: got no out_valid want 10 within 10 cycles");
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 2'b10) begin errors++; $display("FAIL bp_valid%0d: got %b want 10", i, out_valid); end
            checks++; if (out_data !== PT_B) begin errors++; $display("FAIL bp_data%0d: got %h want %h", i, out_data, PT_B); end
            checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 00", i, in_ready); end
            if (i == 2) begin
                force_done = 1'b1;
                in_data0 = FIPS_CT;
            end
            tick();
            force_done = 1'b0;
        end
        out_ready = 2'b10;
        settle();
        tick();
        out_ready = 2'b00;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_idle: got busy %b want 0", busy); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL bp_release_valid: got %b want 00", out_valid); end
        checks++; if (in_ready !== 2'b01) begin errors++; $display("FAIL bp_rr_flip: got %b want 01", in_ready); end
        in_valid = 2'b00;
        settle();
    endtask

    task automatic test_spurious_idle();
        force_done = 1'b1;
        settle();
        tick();
        force_done = 1'b0;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_idle_state: got busy %b want 0", busy); end
        checks++; if (out_data !== PT_B) begin errors++; $display("FAIL spur_idle_data: got %h want %h", out_data, PT_B); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL spur_idle_valid: got %b want 00", out_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        core_en = 1'b0; in_data0 = CT_A; in_valid = 2'b01;
        settle();
        tick();                                   // START
        in_valid = 2'b00;
        tick();                                   // WAIT, counter 0
        for (int i = 0; i < 8; i++) begin
            checks++; if ({err_timeout, out_valid} !== 3'b000) begin errors++; $display("FAIL timeout_early%0d: got err %b valid %b want 0 00", i, err_timeout, out_valid); end
            tick();
        end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b want 1", err_timeout); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_pulse: got %b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after: got %b want 0", busy); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_single_pulse: got %b want 0", err_timeout); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL timeout_no_result: got %b want 00", out_valid); end
        in_valid = 2'b11;
        settle();
        checks++; if (in_ready !== 2'b10) begin errors++; $display("FAIL timeout_rr_flip: got %b want 10", in_ready); end
        in_valid = 2'b00;
        settle();
    endtask

    task automatic test_timeout_vs_done();
        in_data1 = CT_B; in_valid = 2'b10;
        settle();
        tick();                                   // START
        in_valid = 2'b00;
        tick();                                   // WAIT, counter 0
        repeat (8) tick();                        // counter at limit
        force_done = 1'b1;
        settle();
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tie_no_err: got %b want 0", err_timeout); end
        tick();
        force_done = 1'b0;
        settle();
        checks++; if (out_valid !== 2'b10) begin errors++; $display("FAIL tie_valid: got %b want 10", out_valid); end
        checks++; if (out_data !== SPUR) begin errors++; $display("FAIL tie_data: got %h want %h", out_data, SPUR); end
        out_ready = 2'b10;
        tick();
        out_ready = 2'b00;
        core_en = 1'b1;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid_wait();
        in_data0 = FIPS_CT; in_valid = 2'b01;
        settle();
        tick();                                   // START
        in_valid = 2'b00;
        tick();                                   // WAIT, core answers next cycle
        rst = 1'b1;
        tick();                                   // IDLE, late core_done present
        rst = 1'b0;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rstmid_valid: got %b want 00", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_data: got %h want 0", out_data); end
        checks++; if (core_cyphertext !== '0) begin errors++; $display("FAIL rstmid_core_ct: got %h want 0", core_cyphertext); end
        checks++; if ({core_start, err_timeout} !== 2'b00) begin errors++; $display("FAIL rstmid_start_err: got %b want 00", {core_start, err_timeout}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({busy, out_valid} !== 3'b000) begin errors++; $display("FAIL rstmid_late_done%0d: got busy %b valid %b want 0 00", i, busy, out_valid); end
            checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_late_data%0d: got %h want 0", i, out_data); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 2'b00; out_ready = 2'b00; in_data0 = '0; in_data1 = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_spurious_idle();
        test_timeout();
        test_timeout_vs_done();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
